pwd_lock_ctrl: RTL and testbench



---
 rtl/pwd_lock_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pwd_lock_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwd_lock_ctrl.sv
// Password-entry controller for the lock.
// Turns the three debounced, active-low key levels into single-cycle press
// events, assembles an NDIG-digit BCD code and compares it against PWD.
// It drives unlock / err / alarm and locks out after MAX_FAIL consecutive
// wrong codes.
module pwd_lock_ctrl #(
   parameter int unsigned       NDIG     = 4,
   parameter logic [4*NDIG-1:0] PWD      = 16'h1234,
   parameter int unsigned       MAX_FAIL = 3,
   parameter int unsigned       ERR_CYC  = 50_000_000,
   parameter int unsigned       LOCK_CYC = 250_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dekey_inc,
   input  logic              dekey_ok,
   input  logic              dekey_clr,
   output logic [3:0]        cur_digit,
   output logic [1:0]        digit_idx,
   output logic [4*NDIG-1:0] entry,
   output logic              unlock,
   output logic              err,
   output logic              alarm,
   output logic [1:0]        fail_cnt,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_ENTER  = 3'd0,
      S_CHECK  = 3'd1,
      S_OPEN   = 3'd2,
      S_ERROR  = 3'd3,
      S_LOCKED = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cur_digit_q, cur_digit_d;
   logic [1:0]        digit_idx_q, digit_idx_d;
   logic [4*NDIG-1:0] entry_q, entry_d;
   logic [1:0]        fail_cnt_q, fail_cnt_d;
   logic [31:0]       timer_q, timer_d;
   logic              prev_inc_q, prev_ok_q, prev_clr_q;
   logic              unlock_q, err_q, alarm_q;

   logic              press_inc, press_ok, press_clr;

   // Falling-edge detection on the idle-high key levels: one press per key-down.
   assign press_inc = prev_inc_q & ~dekey_inc;
   assign press_ok  = prev_ok_q  & ~dekey_ok;
   assign press_clr = prev_clr_q & ~dekey_clr;

   // Next-state logic: key handling (clr > ok > inc), code check and timeouts.
   always_comb begin
      state_d     = state_q;
      cur_digit_d = cur_digit_q;
      digit_idx_d = digit_idx_q;
      entry_d     = entry_q;
      fail_cnt_d  = fail_cnt_q;

      case (state_q)
         S_ENTER: begin
            if (press_clr) begin
               entry_d     = '0;
               cur_digit_d = '0;
               digit_idx_d = '0;
            end else if (press_ok) begin
               entry_d     = {entry_q[4*NDIG-5:0], cur_digit_q};
               cur_digit_d = '0;
               if (digit_idx_q == 2'(NDIG - 1)) begin
                  digit_idx_d = '0;
                  state_d     = S_CHECK;
               end else begin
                  digit_idx_d = digit_idx_q + 2'd1;
               end
            end else if (press_inc) begin
               cur_digit_d = (cur_digit_q == 4'd9) ? 4'd0 : cur_digit_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (entry_q == PWD) begin
               state_d    = S_OPEN;
               fail_cnt_d = '0;
            end else if (({30'd0, fail_cnt_q} + 32'd1) == MAX_FAIL) begin
               state_d    = S_LOCKED;
               fail_cnt_d = 2'(MAX_FAIL);
            end else begin
               state_d    = S_ERROR;
               fail_cnt_d = fail_cnt_q + 2'd1;
            end
         end
         S_OPEN: begin
            if (press_clr) begin
               state_d     = S_ENTER;
               entry_d     = '0;
               cur_digit_d = '0;
               digit_idx_d = '0;
            end
         end
         S_ERROR: begin
            if (timer_q == 32'(ERR_CYC - 1)) begin
               state_d     = S_ENTER;
               entry_d     = '0;
               cur_digit_d = '0;
               digit_idx_d = '0;
            end
         end
         S_LOCKED: begin
            if (timer_q == 32'(LOCK_CYC - 1)) begin
               state_d     = S_ENTER;
               fail_cnt_d  = '0;
               entry_d     = '0;
               cur_digit_d = '0;
               digit_idx_d = '0;
            end
         end
         default: begin
            state_d     = S_ENTER;
            entry_d     = '0;
            cur_digit_d = '0;
            digit_idx_d = '0;
            fail_cnt_d  = '0;
         end
      endcase

      // Timer runs only while waiting out ERROR/LOCKED and restarts on any move.
      if (state_d != state_q)
         timer_d = '0;
      else if (state_q == S_ERROR || state_q == S_LOCKED)
         timer_d = timer_q + 32'd1;
      else
         timer_d = '0;
   end

   // State, datapath, key history and outputs decoded from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_ENTER;
         cur_digit_q <= '0;
         digit_idx_q <= '0;
         entry_q     <= '0;
         fail_cnt_q  <= '0;
         timer_q     <= '0;
         prev_inc_q  <= 1'b1;
         prev_ok_q   <= 1'b1;
         prev_clr_q  <= 1'b1;
         unlock_q    <= 1'b0;
         err_q       <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_digit_q <= cur_digit_d;
         digit_idx_q <= digit_idx_d;
         entry_q     <= entry_d;
         fail_cnt_q  <= fail_cnt_d;
         timer_q     <= timer_d;
         prev_inc_q  <= dekey_inc;
         prev_ok_q   <= dekey_ok;
         prev_clr_q  <= dekey_clr;
         unlock_q    <= (state_d == S_OPEN);
         err_q       <= (state_d == S_ERROR);
         alarm_q     <= (state_d == S_LOCKED);
      end
   end

   assign cur_digit = cur_digit_q;
   assign digit_idx = digit_idx_q;
   assign entry     = entry_q;
   assign fail_cnt  = fail_cnt_q;
   assign state     = state_q;
   assign unlock    = unlock_q;
   assign err       = err_q;
   assign alarm     = alarm_q;

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Directed bench for pwd_lock_ctrl with short ERROR/LOCKED timeouts.
module tb_pwd_lock_ctrl;

   localparam int NDIG = 4;
   localparam int KINC = 0;
   localparam int KOK  = 1;
   localparam int KCLR = 2;

   logic        clk;
   logic        reset;
   logic        dekey_inc, dekey_ok, dekey_clr;
   logic [3:0]  cur_digit;
   logic [1:0]  digit_idx;
   logic [15:0] entry;
   logic        unlock, err, alarm;
   logic [1:0]  fail_cnt;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;

   pwd_lock_ctrl #(
      .NDIG(NDIG), .PWD(16'h1234), .MAX_FAIL(3), .ERR_CYC(8), .LOCK_CYC(16)
   ) dut (
      .clk(clk), .reset(reset),
      .dekey_inc(dekey_inc), .dekey_ok(dekey_ok), .dekey_clr(dekey_clr),
      .cur_digit(cur_digit), .digit_idx(digit_idx), .entry(entry),
      .unlock(unlock), .err(err), .alarm(alarm),
      .fail_cnt(fail_cnt), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         KINC:    dekey_inc = v;
         KOK:     dekey_ok  = v;
         default: dekey_clr = v;
      endcase
   endtask

   task automatic press(input int k);
      set_key(k, 1'b0);
      tick();
      set_key(k, 1'b1);
      tick();
   endtask

   task automatic dial_digit(input logic [3:0] d);
      for (int i = 0; i < int'(d); i++) press(KINC);
      press(KOK);
   endtask

   // Leaves ok held low with the DUT sitting in CHECK.
   task automatic dial_to_check(input logic [15:0] code);
      for (int i = 3; i >= 1; i--) dial_digit(code[4*i +: 4]);
      for (int i = 0; i < int'(code[3:0]); i++) press(KINC);
      dekey_ok = 1'b0;
      tick();
   endtask

   task automatic wait_enter(input string tag);
      int n = 0;
      while (state !== 3'd0 && n < 100) begin
         tick();
         n++;
      end
      check_val(tag, 32'(n < 100), 32'd1);
   endtask

   task automatic wrong_code(input logic [15:0] code, input string tag);
      dial_to_check(code);
      dekey_ok = 1'b1;
      tick();
      wait_enter(tag);
   endtask

   task automatic pulse_reset_check(input string tag);
      reset = 1'b0;
      #2;
      check_val({tag, "_state"}, 32'(state), 32'd0);
      check_val({tag, "_entry"}, 32'(entry), 32'd0);
      check_val({tag, "_idx"}, 32'(digit_idx), 32'd0);
      check_val({tag, "_cur"}, 32'(cur_digit), 32'd0);
      check_val({tag, "_fail"}, 32'(fail_cnt), 32'd0);
      check_val({tag, "_flags"}, {29'd0, unlock, err, alarm}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      reset = 1'b0;
      dekey_inc = 1'b1;
      dekey_ok  = 1'b1;
      dekey_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_entry", 32'(entry), 32'd0);
      check_val("rst_flags", {29'd0, unlock, err, alarm}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // 1: correct code opens, clr relocks
      dial_to_check(16'h1234);
      check_val("t1_check_state", 32'(state), 32'd1);
      check_val("t1_entry", 32'(entry), 32'h1234);
      check_val("t1_check_unlock", 32'(unlock), 32'd0);
      dekey_ok = 1'b1;
      tick();
      check_val("t1_open_state", 32'(state), 32'd2);
      check_val("t1_unlock", 32'(unlock), 32'd1);
      check_val("t1_fail", 32'(fail_cnt), 32'd0);
      press(KINC);
      check_val("t1_open_inc_ignored", 32'(cur_digit), 32'd0);
      press(KCLR);
      check_val("t1_clr_state", 32'(state), 32'd0);
      check_val("t1_clr_entry", 32'(entry), 32'd0);
      check_val("t1_clr_unlock", 32'(unlock), 32'd0);

      // 2: increment wrap and held key
      for (int i = 0; i < 10; i++) begin
         press(KINC);
         check_val($sformatf("t2_inc%0d", i), 32'(cur_digit), 32'((i + 1) % 10));
      end
      dekey_inc = 1'b0;
      repeat (20) tick();
      dekey_inc = 1'b1;
      tick();
      check_val("t2_hold", 32'(cur_digit), 32'd1);
      press(KCLR);

      // 3: wrong code, ERROR for 8 cycles, inc presses lost
      dial_to_check(16'h1235);
      dekey_ok = 1'b1;
      tick();
      check_val("t3_err_state", 32'(state), 32'd3);
      check_val("t3_fail", 32'(fail_cnt), 32'd1);
      n = 0;
      while (err === 1'b1 && n < 30) begin
         n++;
         dekey_inc = (n == 2 || n == 4) ? 1'b0 : 1'b1;
         tick();
      end
      dekey_inc = 1'b1;
      check_val("t3_err_cycles", 32'(n), 32'd8);
      check_val("t3_after_state", 32'(state), 32'd0);
      check_val("t3_after_entry", 32'(entry), 32'd0);
      check_val("t3_after_cur", 32'(cur_digit), 32'd0);
      check_val("t3_after_fail", 32'(fail_cnt), 32'd1);

      // 4: clear fail count with a good code, then three wrong codes
      dial_to_check(16'h1234);
      dekey_ok = 1'b1;
      tick();
      check_val("t4_open_fail", 32'(fail_cnt), 32'd0);
      press(KCLR);
      wrong_code(16'h0000, "t4_w1_done");
      check_val("t4_w1_fail", 32'(fail_cnt), 32'd1);
      wrong_code(16'h9999, "t4_w2_done");
      check_val("t4_w2_fail", 32'(fail_cnt), 32'd2);
      dial_to_check(16'h4321);
      dekey_ok = 1'b1;
      tick();
      check_val("t4_lock_state", 32'(state), 32'd4);
      check_val("t4_lock_fail", 32'(fail_cnt), 32'd3);
      n = 0;
      while (alarm === 1'b1 && n < 50) begin
         n++;
         dekey_clr = (n == 3) ? 1'b0 : 1'b1;
         tick();
      end
      dekey_clr = 1'b1;
      check_val("t4_alarm_cycles", 32'(n), 32'd16);
      check_val("t4_after_state", 32'(state), 32'd0);
      check_val("t4_after_fail", 32'(fail_cnt), 32'd0);

      // 5: simultaneous presses, clr wins
      dial_digit(4'd5);
      dial_digit(4'd7);
      press(KINC);
      press(KINC);
      check_val("t5_idx", 32'(digit_idx), 32'd2);
      check_val("t5_entry", 32'(entry), 32'h0057);
      check_val("t5_cur", 32'(cur_digit), 32'd2);
      dekey_inc = 1'b0;
      dekey_ok  = 1'b0;
      dekey_clr = 1'b0;
      tick();
      dekey_inc = 1'b1;
      dekey_ok  = 1'b1;
      dekey_clr = 1'b1;
      tick();
      check_val("t5_entry_clr", 32'(entry), 32'd0);
      check_val("t5_idx_clr", 32'(digit_idx), 32'd0);
      check_val("t5_cur_clr", 32'(cur_digit), 32'd0);
      check_val("t5_state", 32'(state), 32'd0);

      // 6: asynchronous reset mid-entry and in LOCKED
      dial_digit(4'd3);
      dial_digit(4'd1);
      press(KINC);
      check_val("t6_pre_idx", 32'(digit_idx), 32'd2);
      pulse_reset_check("t6_mid");
      wrong_code(16'h0001, "t6_w1_done");
      wrong_code(16'h0002, "t6_w2_done");
      dial_to_check(16'h0003);
      dekey_ok = 1'b1;
      tick();
      repeat (3) tick();
      check_val("t6_pre_alarm", 32'(alarm), 32'd1);
      pulse_reset_check("t6_lock");
      check_val("t6_post_fail", 32'(fail_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
